// File: rtl/core.sv
// Shared core types.
//   ALU_OP : operation code seen by the shared integer ALU.
package core;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      SLL  = 4'd5,
      SRL  = 4'd6,
      SRA  = 4'd7,
      SLT  = 4'd8,
      SLTU = 4'd9
   } ALU_OP;

endpackage

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters (port 0: EX-stage integer
// path, port 1: branch/compare side-path). Round-robin grant, at most one issue
// per cycle, result captured into a 1-entry per-port response buffer one edge
// after accept.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   flush                           drop buffered responses, block issue this cycle
//   reqN_valid/ready                request handshake (ready is the grant)
//   reqN_op1/op2/operation/tag      request payload
//   alu_op1/op2/operation           drive to the shared ALU
//   alu_result                      ALU result, same cycle
//   rspN_valid/ready/data/tag       buffered response handshake and payload
//
// Response buffer FSM (one per port)
//   state     | meaning
//   RSP_EMPTY | no result held; port eligible for issue
//   RSP_FULL  | result held stable until rspN_ready; re-issue only with ready
module alu_share_arbiter
   import core::*;
#(
   parameter int Data_Width = 32,
   parameter int TAG_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [Data_Width-1:0] req0_op1,
   input  logic [Data_Width-1:0] req0_op2,
   input  ALU_OP                 req0_operation,
   input  logic [TAG_W-1:0]      req0_tag,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [Data_Width-1:0] req1_op1,
   input  logic [Data_Width-1:0] req1_op2,
   input  ALU_OP                 req1_operation,
   input  logic [TAG_W-1:0]      req1_tag,

   output logic [Data_Width-1:0] alu_op1,
   output logic [Data_Width-1:0] alu_op2,
   output ALU_OP                 alu_operation,
   input  logic [Data_Width-1:0] alu_result,

   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [Data_Width-1:0] rsp0_data,
   output logic [TAG_W-1:0]      rsp0_tag,

   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [Data_Width-1:0] rsp1_data,
   output logic [TAG_W-1:0]      rsp1_tag
);

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

   rsp_state_t            state0_q, state0_d;
   rsp_state_t            state1_q, state1_d;
   logic [Data_Width-1:0] data0_q, data0_d;
   logic [Data_Width-1:0] data1_q, data1_d;
   logic [TAG_W-1:0]      tag0_q, tag0_d;
   logic [TAG_W-1:0]      tag1_q, tag1_d;
   logic                  last_grant_q, last_grant_d;

   logic                  elig0, elig1;
   logic                  grant0, grant1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state0_q     <= RSP_EMPTY;
         state1_q     <= RSP_EMPTY;
         data0_q      <= '0;
         data1_q      <= '0;
         tag0_q       <= '0;
         tag1_q       <= '0;
         last_grant_q <= 1'b1;
      end else begin
         state0_q     <= state0_d;
         state1_q     <= state1_d;
         data0_q      <= data0_d;
         data1_q      <= data1_d;
         tag0_q       <= tag0_d;
         tag1_q       <= tag1_d;
         last_grant_q <= last_grant_d;
      end
   end

   // A FULL buffer can take a new result only when it is being drained in
   // the same cycle. Grants are forced low while reset is held.
   always_comb begin
      elig0  = req0_valid & ~flush & ((state0_q == RSP_EMPTY) | rsp0_ready);
      elig1  = req1_valid & ~flush & ((state1_q == RSP_EMPTY) | rsp1_ready);
      grant0 = rst_n & elig0 & (~elig1 | last_grant_q);
      grant1 = rst_n & elig1 & (~elig0 | ~last_grant_q);
   end

   always_comb begin
      state0_d      = state0_q;
      state1_d      = state1_q;
      data0_d       = data0_q;
      data1_d       = data1_q;
      tag0_d        = tag0_q;
      tag1_d        = tag1_q;
      last_grant_d  = last_grant_q;
      alu_op1       = '0;
      alu_op2       = '0;
      alu_operation = ADD;

      if (grant0) begin
         alu_op1       = req0_op1;
         alu_op2       = req0_op2;
         alu_operation = req0_operation;
         last_grant_d  = 1'b0;
      end else if (grant1) begin
         alu_op1       = req1_op1;
         alu_op2       = req1_op2;
         alu_operation = req1_operation;
         last_grant_d  = 1'b1;
      end

      // flush wins over everything; grants are already blocked by it.
      if (flush) begin
         state0_d = RSP_EMPTY;
      end else if (grant0) begin
         state0_d = RSP_FULL;
         data0_d  = alu_result;
         tag0_d   = req0_tag;
      end else if ((state0_q == RSP_FULL) && rsp0_ready) begin
         state0_d = RSP_EMPTY;
      end

      if (flush) begin
         state1_d = RSP_EMPTY;
      end else if (grant1) begin
         state1_d = RSP_FULL;
         data1_d  = alu_result;
         tag1_d   = req1_tag;
      end else if ((state1_q == RSP_FULL) && rsp1_ready) begin
         state1_d = RSP_EMPTY;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = (state0_q == RSP_FULL);
   assign rsp1_valid = (state1_q == RSP_FULL);
   assign rsp0_data  = data0_q;
   assign rsp1_data  = data1_q;
   assign rsp0_tag   = tag0_q;
   assign rsp1_tag   = tag1_q;

endmodule
